// File: rtl/pico_ctrl_if.sv
// Control bus between the picoMips sequencer, its program ROM and the accumulator ALU / register file.
interface pico_ctrl_if #(
    parameter int PC_WIDTH = 8,
    parameter int IW       = 16,
    parameter int RA_WIDTH = 3
);
    logic [IW-1:0]       Instr;
    logic [PC_WIDTH-1:0] PC;
    logic [2:0]          Func;
    logic                WE;
    logic                SelSW;
    logic                SelImm;
    logic [7:0]          Imm;
    logic [RA_WIDTH-1:0] RegAddr;
    logic                RegWE;

    // Sequencer side: reads the instruction, drives the ROM address and datapath controls.
    modport master (
        input  Instr,
        output PC, Func, WE, SelSW, SelImm, Imm, RegAddr, RegWE
    );

    // ROM / datapath side.
    modport slave (
        output Instr,
        input  PC, Func, WE, SelSW, SelImm, Imm, RegAddr, RegWE
    );
endinterface

// File: rtl/pico_ctrl.sv
// picoMips instruction sequencer: program counter, instruction decode and the
// blocking wait-for-button handshake.
module pico_ctrl #(
    parameter int PC_WIDTH = 8,
    parameter int IW       = 16,
    parameter int RA_WIDTH = 3
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Btn,
    output logic        Waiting,
    pico_ctrl_if.master bus
);
    typedef enum logic [1:0] {RST, EXEC, W_PRESS, W_REL} state_t;

    localparam logic [2:0] OP_RTA  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_LSW  = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b011;
    localparam logic [2:0] OP_ATR  = 3'b100;
    localparam logic [2:0] OP_MULI = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_WAIT = 3'b111;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pcInc_d;
    logic [PC_WIDTH-1:0] pcJmp_d;
    logic                waiting_q;
    logic                btnMeta_q;
    logic                btnSync_q;
    logic [2:0]          opcode;
    logic                inExec;
    logic                unusedRsvd;

    assign opcode     = bus.Instr[IW-1 -: 3];
    assign inExec     = (state_q == EXEC);
    assign pcInc_d    = pc_q + PC_WIDTH'(1);
    assign pcJmp_d    = PC_WIDTH'(bus.Instr[7:0]);
    assign unusedRsvd = ^bus.Instr[12:11];

    // Two-flop synchroniser for the asynchronous push button.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            btnMeta_q <= 1'b0;
            btnSync_q <= 1'b0;
        end else begin
            btnMeta_q <= Btn;
            btnSync_q <= btnMeta_q;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= RST;
            pc_q      <= '0;
            waiting_q <= 1'b0;
        end else begin
            case (state_q)
                RST: begin
                    state_q   <= EXEC;
                    pc_q      <= '0;
                    waiting_q <= 1'b0;
                end
                EXEC: begin
                    if (opcode == OP_WAIT) begin
                        state_q   <= W_PRESS;
                        waiting_q <= 1'b1;
                    end else if (opcode == OP_JMP) begin
                        pc_q <= pcJmp_d;
                    end else begin
                        pc_q <= pcInc_d;
                    end
                end
                W_PRESS: begin
                    if (btnSync_q) begin
                        state_q <= W_REL;
                    end
                end
                // The WAIT retires only once the button has been let go.
                W_REL: begin
                    if (!btnSync_q) begin
                        state_q   <= EXEC;
                        pc_q      <= pcInc_d;
                        waiting_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RST;
                    waiting_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.WE     = 1'b0;
        bus.SelSW  = 1'b0;
        bus.SelImm = 1'b0;
        bus.RegWE  = 1'b0;
        if (inExec) begin
            case (opcode)
                OP_RTA, OP_ADD: bus.WE = 1'b1;
                OP_LSW: begin
                    bus.WE    = 1'b1;
                    bus.SelSW = 1'b1;
                end
                OP_ADDI, OP_MULI: begin
                    bus.WE     = 1'b1;
                    bus.SelImm = 1'b1;
                end
                OP_ATR:  bus.RegWE = 1'b1;
                default: bus.WE    = 1'b0;
            endcase
        end
    end

    assign bus.PC      = pc_q;
    assign bus.Func    = opcode;
    assign bus.Imm     = bus.Instr[7:0];
    assign bus.RegAddr = bus.Instr[8+RA_WIDTH-1:8];
    assign Waiting     = waiting_q;
endmodule

// File: tb/tb_pico_ctrl.sv
// Self-checking bench for pico_ctrl: directed scenarios plus a randomized program
// compared against a cycle-level reference model of the instruction set.
module tb_pico_ctrl;
    localparam int M_RESET   = 0;
    localparam int M_RUN     = 1;
    localparam int M_PRESS   = 2;
    localparam int M_RELEASE = 3;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;
    logic Btn    = 1'b0;
    logic Waiting;

    logic [15:0] rom [256];

    int errors = 0;
    int checks = 0;

    int         mMode;
    logic [7:0] mPc;
    logic       btnLag [$];

    pico_ctrl_if bus ();

    pico_ctrl dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .Btn     (Btn),
        .Waiting (Waiting),
        .bus     (bus)
    );

    assign bus.Instr = rom[bus.PC];

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] r, input logic [7:0] imm);
        return {op, 2'b00, r, imm};
    endfunction

    // Reference model: one step of the instruction set, with the button seen two edges late.
    task automatic tick();
        logic [15:0] ins;
        logic [2:0]  op;
        logic        btnS;
        ins  = rom[mPc];
        op   = ins[15:13];
        btnS = btnLag[0];
        case (mMode)
            M_RESET: mMode = M_RUN;
            M_RUN: begin
                if (op == 3'd7) mMode = M_PRESS;
                else if (op == 3'd6) mPc = ins[7:0];
                else mPc = mPc + 8'd1;
            end
            M_PRESS: if (btnS) mMode = M_RELEASE;
            default: if (!btnS) begin
                mMode = M_RUN;
                mPc   = mPc + 8'd1;
            end
        endcase
        void'(btnLag.pop_front());
        btnLag.push_back(Btn);
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        nReset = 1'b0;
        mMode  = M_RESET;
        mPc    = 8'd0;
        btnLag = '{1'b0, 1'b0};
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        #1;
    endtask

    task automatic loadStraight();
        for (int i = 0; i < 256; i++) rom[i] = mk(3'd0, 3'd0, 8'd0);
        rom[0]  = mk(3'd2, 3'd0, 8'd0);
        rom[1]  = mk(3'd3, 3'd0, 8'd5);
        rom[2]  = mk(3'd4, 3'd3, 8'd0);
        rom[3]  = mk(3'd5, 3'd0, 8'h40);
        rom[4]  = mk(3'd6, 3'd0, 8'h10);
        rom[16] = mk(3'd1, 3'd2, 8'd0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) rom[i] = mk(3'd3, 3'd0, 8'd1);
        rom[0] = {3'b010, 2'b11, 3'b101, 8'hA7};
        nReset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (bus.PC !== 8'd0) begin errors++; $display("[TB] FAIL rst_pc got=%0h want=0", bus.PC); end
        checks++; if (bus.WE !== 1'b0) begin errors++; $display("[TB] FAIL rst_we got=%b want=0", bus.WE); end
        checks++; if (bus.RegWE !== 1'b0) begin errors++; $display("[TB] FAIL rst_regwe got=%b want=0", bus.RegWE); end
        checks++; if (bus.SelSW !== 1'b0) begin errors++; $display("[TB] FAIL rst_selsw got=%b want=0", bus.SelSW); end
        checks++; if (bus.SelImm !== 1'b0) begin errors++; $display("[TB] FAIL rst_selimm got=%b want=0", bus.SelImm); end
        checks++; if (Waiting !== 1'b0) begin errors++; $display("[TB] FAIL rst_waiting got=%b want=0", Waiting); end
        checks++; if (bus.Func !== 3'b010) begin errors++; $display("[TB] FAIL rst_func got=%b want=010", bus.Func); end
        checks++; if (bus.Imm !== 8'hA7) begin errors++; $display("[TB] FAIL rst_imm got=%0h want=a7", bus.Imm); end
        checks++; if (bus.RegAddr !== 3'd5) begin errors++; $display("[TB] FAIL rst_regaddr got=%0d want=5", bus.RegAddr); end
    endtask

    task automatic test_straight_line();
        logic [3:0] expCtl  [4] = '{4'b1010, 4'b1001, 4'b0100, 4'b1001};
        logic [7:0] expImm  [4] = '{8'h00, 8'h05, 8'h00, 8'h40};
        logic [2:0] expReg  [4] = '{3'd0, 3'd0, 3'd3, 3'd0};
        logic [2:0] expFunc [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
        logic [3:0] e;
        loadStraight();
        Btn = 1'b0;
        doReset();
        checks++; if (bus.PC !== 8'd0) begin errors++; $display("[TB] FAIL line_rst_pc got=%0h want=0", bus.PC); end
        checks++; if (bus.WE !== 1'b0) begin errors++; $display("[TB] FAIL line_rst_we got=%b want=0", bus.WE); end
        checks++; if (bus.SelSW !== 1'b0) begin errors++; $display("[TB] FAIL line_rst_selsw got=%b want=0", bus.SelSW); end
        for (int i = 0; i < 4; i++) begin
            tick();
            e = expCtl[i];
            checks++; if (bus.PC !== 8'(i)) begin errors++; $display("[TB] FAIL line_pc step=%0d got=%0h want=%0h", i, bus.PC, i); end
            checks++; if (bus.WE !== e[3]) begin errors++; $display("[TB] FAIL line_we step=%0d got=%b want=%b", i, bus.WE, e[3]); end
            checks++; if (bus.RegWE !== e[2]) begin errors++; $display("[TB] FAIL line_regwe step=%0d got=%b want=%b", i, bus.RegWE, e[2]); end
            checks++; if (bus.SelSW !== e[1]) begin errors++; $display("[TB] FAIL line_selsw step=%0d got=%b want=%b", i, bus.SelSW, e[1]); end
            checks++; if (bus.SelImm !== e[0]) begin errors++; $display("[TB] FAIL line_selimm step=%0d got=%b want=%b", i, bus.SelImm, e[0]); end
            checks++; if (bus.Imm !== expImm[i]) begin errors++; $display("[TB] FAIL line_imm step=%0d got=%0h want=%0h", i, bus.Imm, expImm[i]); end
            checks++; if (bus.RegAddr !== expReg[i]) begin errors++; $display("[TB] FAIL line_regaddr step=%0d got=%0d want=%0d", i, bus.RegAddr, expReg[i]); end
            checks++; if (bus.Func !== expFunc[i]) begin errors++; $display("[TB] FAIL line_func step=%0d got=%b want=%b", i, bus.Func, expFunc[i]); end
        end
    endtask

    task automatic test_jump();
        loadStraight();
        Btn = 1'b0;
        doReset();
        repeat (5) tick();
        checks++; if (bus.PC !== 8'd4) begin errors++; $display("[TB] FAIL jmp_at_pc got=%0h want=4", bus.PC); end
        checks++; if (bus.WE !== 1'b0) begin errors++; $display("[TB] FAIL jmp_we got=%b want=0", bus.WE); end
        checks++; if (bus.RegWE !== 1'b0) begin errors++; $display("[TB] FAIL jmp_regwe got=%b want=0", bus.RegWE); end
        checks++; if (bus.Func !== 3'd6) begin errors++; $display("[TB] FAIL jmp_func got=%b want=110", bus.Func); end
        tick();
        checks++; if (bus.PC !== 8'h10) begin errors++; $display("[TB] FAIL jmp_target got=%0h want=10", bus.PC); end
        checks++; if (bus.WE !== 1'b1) begin errors++; $display("[TB] FAIL jmp_target_we got=%b want=1", bus.WE); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) rom[i] = mk(3'd0, 3'd0, 8'd0);
        rom[0]   = mk(3'd6, 3'd0, 8'hFF);
        rom[255] = mk(3'd1, 3'd1, 8'd0);
        Btn = 1'b0;
        doReset();
        tick();
        tick();
        checks++; if (bus.PC !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_pc255 got=%0h want=ff", bus.PC); end
        checks++; if (bus.WE !== 1'b1) begin errors++; $display("[TB] FAIL wrap_add_we got=%b want=1", bus.WE); end
        checks++; if (bus.RegAddr !== 3'd1) begin errors++; $display("[TB] FAIL wrap_add_reg got=%0d want=1", bus.RegAddr); end
        tick();
        checks++; if (bus.PC !== 8'h00) begin errors++; $display("[TB] FAIL wrap_pc0 got=%0h want=0", bus.PC); end
    endtask

    task automatic test_wait();
        int reached;
        for (int i = 0; i < 256; i++) rom[i] = mk(3'd3, 3'd0, 8'(i));
        rom[7] = mk(3'd7, 3'd0, 8'd0);
        rom[8] = mk(3'd3, 3'd0, 8'h99);
        Btn = 1'b0;
        doReset();
        repeat (8) tick();
        checks++; if (bus.PC !== 8'd7) begin errors++; $display("[TB] FAIL wait_fetch_pc got=%0h want=7", bus.PC); end
        checks++; if (Waiting !== 1'b0) begin errors++; $display("[TB] FAIL wait_fetch_waiting got=%b want=0", Waiting); end
        tick();
        reached = -1;
        // Btn is high for exactly three cycles, starting five cycles into the stall.
        for (int k = 0; k < 30; k++) begin
            Btn = (k >= 5 && k < 8);
            tick();
            if (bus.PC === 8'd8) begin
                reached = k;
                break;
            end
            checks++; if (Waiting !== 1'b1) begin errors++; $display("[TB] FAIL wait_stall_waiting k=%0d got=%b want=1", k, Waiting); end
            checks++; if (bus.PC !== 8'd7) begin errors++; $display("[TB] FAIL wait_stall_pc k=%0d got=%0h want=7", k, bus.PC); end
            checks++; if (bus.WE !== 1'b0 || bus.RegWE !== 1'b0) begin errors++; $display("[TB] FAIL wait_stall_we k=%0d got=%b%b want=00", k, bus.WE, bus.RegWE); end
        end
        checks++; if (reached != 10) begin errors++; $display("[TB] FAIL wait_release_time got=%0d want=10", reached); end
        checks++; if (Waiting !== 1'b0) begin errors++; $display("[TB] FAIL wait_done_waiting got=%b want=0", Waiting); end
        checks++; if (bus.WE !== 1'b1) begin errors++; $display("[TB] FAIL wait_done_we got=%b want=1", bus.WE); end
    endtask

    task automatic test_wait_held();
        int reached;
        for (int i = 0; i < 256; i++) rom[i] = mk(3'd3, 3'd0, 8'd1);
        rom[2] = mk(3'd7, 3'd0, 8'd0);
        rom[3] = mk(3'd2, 3'd0, 8'd0);
        Btn = 1'b1;
        doReset();
        repeat (3) tick();
        checks++; if (bus.PC !== 8'd2) begin errors++; $display("[TB] FAIL held_fetch_pc got=%0h want=2", bus.PC); end
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.PC !== 8'd2 || Waiting !== 1'b1) begin errors++; $display("[TB] FAIL held_stall k=%0d got pc=%0h waiting=%b want pc=2 waiting=1", k, bus.PC, Waiting); end
        end
        Btn = 1'b0;
        reached = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.PC === 8'd3) begin
                reached = k;
                break;
            end
        end
        checks++; if (reached != 2) begin errors++; $display("[TB] FAIL held_release_time got=%0d want=2", reached); end
        checks++; if (bus.WE !== 1'b1 || bus.SelSW !== 1'b1) begin errors++; $display("[TB] FAIL held_next_ctl got=%b%b want=11", bus.WE, bus.SelSW); end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 256; i++) rom[i] = mk(3'd3, 3'd0, 8'd2);
        rom[0]    = mk(3'd2, 3'd0, 8'd0);
        rom[1]    = mk(3'd6, 3'd0, 8'h22);
        rom[8'h22] = mk(3'd7, 3'd0, 8'd0);
        Btn = 1'b0;
        doReset();
        repeat (3) tick();
        checks++; if (bus.PC !== 8'h22) begin errors++; $display("[TB] FAIL rmw_fetch_pc got=%0h want=22", bus.PC); end
        tick();
        Btn = 1'b1;
        repeat (3) tick();
        checks++; if (Waiting !== 1'b1 || bus.PC !== 8'h22) begin errors++; $display("[TB] FAIL rmw_in_release got pc=%0h waiting=%b want pc=22 waiting=1", bus.PC, Waiting); end
        #2;
        nReset = 1'b0;
        #1;
        checks++; if (bus.PC !== 8'd0) begin errors++; $display("[TB] FAIL rmw_async_pc got=%0h want=0", bus.PC); end
        checks++; if (Waiting !== 1'b0) begin errors++; $display("[TB] FAIL rmw_async_waiting got=%b want=0", Waiting); end
        checks++; if (bus.WE !== 1'b0 || bus.RegWE !== 1'b0) begin errors++; $display("[TB] FAIL rmw_async_we got=%b%b want=00", bus.WE, bus.RegWE); end
        Btn = 1'b0;
        doReset();
        checks++; if (bus.PC !== 8'd0 || bus.WE !== 1'b0) begin errors++; $display("[TB] FAIL rmw_rst_cycle got pc=%0h we=%b want pc=0 we=0", bus.PC, bus.WE); end
        tick();
        checks++; if (bus.PC !== 8'd0 || bus.WE !== 1'b1 || bus.SelSW !== 1'b1) begin errors++; $display("[TB] FAIL rmw_first_fetch got pc=%0h we=%b sw=%b want pc=0 we=1 sw=1", bus.PC, bus.WE, bus.SelSW); end
        tick();
        checks++; if (bus.PC !== 8'd1) begin errors++; $display("[TB] FAIL rmw_second_fetch got=%0h want=1", bus.PC); end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic [2:0]  op;
        logic        exec, eWe, eRegWe, eSw, eImm, eWait;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom());
        Btn = 1'b0;
        doReset();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) doReset();
            if ($urandom_range(0, 3) == 0) Btn = ~Btn;
            tick();
            ins    = rom[mPc];
            op     = ins[15:13];
            exec   = (mMode == M_RUN);
            eWe    = exec && (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd3 || op == 3'd5);
            eRegWe = exec && (op == 3'd4);
            eSw    = exec && (op == 3'd2);
            eImm   = exec && (op == 3'd3 || op == 3'd5);
            eWait  = (mMode == M_PRESS || mMode == M_RELEASE);
            checks++; if (bus.PC !== mPc) begin errors++; $display("[TB] FAIL rnd_pc n=%0d got=%0h want=%0h", n, bus.PC, mPc); end
            checks++; if (bus.WE !== eWe) begin errors++; $display("[TB] FAIL rnd_we n=%0d got=%b want=%b", n, bus.WE, eWe); end
            checks++; if (bus.RegWE !== eRegWe) begin errors++; $display("[TB] FAIL rnd_regwe n=%0d got=%b want=%b", n, bus.RegWE, eRegWe); end
            checks++; if (bus.SelSW !== eSw) begin errors++; $display("[TB] FAIL rnd_selsw n=%0d got=%b want=%b", n, bus.SelSW, eSw); end
            checks++; if (bus.SelImm !== eImm) begin errors++; $display("[TB] FAIL rnd_selimm n=%0d got=%b want=%b", n, bus.SelImm, eImm); end
            checks++; if (Waiting !== eWait) begin errors++; $display("[TB] FAIL rnd_waiting n=%0d got=%b want=%b", n, Waiting, eWait); end
            checks++; if (bus.Func !== op) begin errors++; $display("[TB] FAIL rnd_func n=%0d got=%b want=%b", n, bus.Func, op); end
            checks++; if (bus.Imm !== ins[7:0]) begin errors++; $display("[TB] FAIL rnd_imm n=%0d got=%0h want=%0h", n, bus.Imm, ins[7:0]); end
            checks++; if (bus.RegAddr !== ins[10:8]) begin errors++; $display("[TB] FAIL rnd_regaddr n=%0d got=%0d want=%0d", n, bus.RegAddr, ins[10:8]); end
        end
    endtask

    initial begin
        $display("[TB] pico_ctrl bench start");
        test_reset();
        test_straight_line();
        test_jump();
        test_wrap();
        test_wait();
        test_wait_held();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
